// File: rtl/regex_job_sequencer.sv
// regex_job_sequencer
// Drives the AXI_top register ports on behalf of a host: streams code/string
// words into core memory, launches a match job, waits for completion and
// returns the verdict together with the elapsed clock count read from the core.
// The command and status encodings default to the AXI_top register map and
// are exposed as parameters so they can follow that map if it changes.
// Optional feature macro: REGEX_SEQ_STATS_EN adds saturating result counters
// (stat_accepted, stat_rejected, stat_errors).

module regex_job_sequencer #(
`ifdef REGEX_SEQ_STATS_EN
    parameter int CNT_WIDTH              = 16,
`endif
    parameter int START_TIMEOUT          = 16,
    parameter int REG_WIDTH              = 32,
    parameter int CMD_NOP                = 0,
    parameter int CMD_WRITE              = 1,
    parameter int CMD_START              = 2,
    parameter int CMD_READ_ELAPSED_CLOCK = 3,
    parameter int STATUS_RUNNING         = 1,
    parameter int STATUS_ACCEPTED        = 2,
    parameter int STATUS_REJECTED        = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    // memory-write beats
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [REG_WIDTH-1:0] wr_addr,
    input  logic [REG_WIDTH-1:0] wr_data,
    // job descriptors
    input  logic                 job_valid,
    output logic                 job_ready,
    input  logic [REG_WIDTH-1:0] job_start_cc,
    input  logic [REG_WIDTH-1:0] job_end_cc,
    // results
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [1:0]           res_code,
    output logic [REG_WIDTH-1:0] res_cc,
    output logic                 busy,
    // AXI_top register ports
    output logic [REG_WIDTH-1:0] address_register,
    output logic [REG_WIDTH-1:0] data_in_register,
    output logic [REG_WIDTH-1:0] start_cc_pointer_register,
    output logic [REG_WIDTH-1:0] end_cc_pointer_register,
    output logic [REG_WIDTH-1:0] cmd_register,
    input  logic [REG_WIDTH-1:0] status_register,
    input  logic [REG_WIDTH-1:0] data_o_register
`ifdef REGEX_SEQ_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0] stat_accepted,
    output logic [CNT_WIDTH-1:0] stat_rejected,
    output logic [CNT_WIDTH-1:0] stat_errors
`endif
);

    localparam int TW = $clog2(START_TIMEOUT + 1);

    localparam logic [1:0] CODE_REJECTED = 2'b00;
    localparam logic [1:0] CODE_ACCEPTED = 2'b01;
    localparam logic [1:0] CODE_TIMEOUT  = 2'b10;
    localparam logic [1:0] CODE_PROTOCOL = 2'b11;

    typedef enum logic [3:0] {
        IDLE,
        WR_SETUP,
        WR_CMD,
        JOB_SETUP,
        START,
        RUN,
        CC_REQ,
        CC_WAIT,
        DONE
    } state_t;

    state_t                 state_reg, state_next;
    logic [TW-1:0]          timer_reg, timer_next;
    logic [REG_WIDTH-1:0]   cmd_reg, cmd_next;
    logic [REG_WIDTH-1:0]   addr_reg, addr_next;
    logic [REG_WIDTH-1:0]   data_in_reg, data_in_next;
    logic [REG_WIDTH-1:0]   start_ptr_reg, start_ptr_next;
    logic [REG_WIDTH-1:0]   end_ptr_reg, end_ptr_next;
    logic [1:0]             res_code_reg, res_code_next;
    logic [REG_WIDTH-1:0]   res_cc_reg, res_cc_next;

    logic status_running;
    logic status_accepted;
    logic status_rejected;

    assign status_running  = (status_register == REG_WIDTH'(STATUS_RUNNING));
    assign status_accepted = (status_register == REG_WIDTH'(STATUS_ACCEPTED));
    assign status_rejected = (status_register == REG_WIDTH'(STATUS_REJECTED));

    // Host-facing handshakes and status are decoded straight from the state.
    assign wr_ready  = (state_reg == IDLE);
    assign job_ready = (state_reg == IDLE) && !wr_valid;
    assign res_valid = (state_reg == DONE);
    assign busy      = (state_reg != IDLE);
    assign res_code  = res_code_reg;
    assign res_cc    = res_cc_reg;

    assign address_register          = addr_reg;
    assign data_in_register          = data_in_reg;
    assign start_cc_pointer_register = start_ptr_reg;
    assign end_cc_pointer_register   = end_ptr_reg;
    assign cmd_register              = cmd_reg;

    // Next-state logic; the command is derived from the state being entered
    // so cmd_register is a clean register that tracks the FSM one-for-one.
    always_comb begin
        state_next     = state_reg;
        timer_next     = timer_reg;
        addr_next      = addr_reg;
        data_in_next   = data_in_reg;
        start_ptr_next = start_ptr_reg;
        end_ptr_next   = end_ptr_reg;
        res_code_next  = res_code_reg;
        res_cc_next    = res_cc_reg;
        cmd_next       = REG_WIDTH'(CMD_NOP);

        case (state_reg)
            IDLE: begin
                if (wr_valid) begin
                    addr_next    = wr_addr;
                    data_in_next = wr_data;
                    state_next   = WR_SETUP;
                end else if (job_valid) begin
                    if (job_end_cc < job_start_cc) begin
                        // Empty/inverted range: report without touching the core.
                        res_code_next = CODE_PROTOCOL;
                        res_cc_next   = '0;
                        state_next    = DONE;
                    end else begin
                        start_ptr_next = job_start_cc;
                        end_ptr_next   = job_end_cc;
                        state_next     = JOB_SETUP;
                    end
                end
            end
            WR_SETUP: state_next = WR_CMD;
            WR_CMD:   state_next = IDLE;
            JOB_SETUP: begin
                timer_next = '0;
                state_next = START;
            end
            START: begin
                if (status_running) begin
                    state_next = RUN;
                end else if (timer_reg == TW'(START_TIMEOUT - 1)) begin
                    res_code_next = CODE_TIMEOUT;
                    res_cc_next   = '0;
                    state_next    = DONE;
                end else begin
                    timer_next = timer_reg + TW'(1);
                end
            end
            RUN: begin
                if (status_running) begin
                    state_next = RUN;
                end else if (status_accepted) begin
                    res_code_next = CODE_ACCEPTED;
                    state_next    = CC_REQ;
                end else if (status_rejected) begin
                    res_code_next = CODE_REJECTED;
                    state_next    = CC_REQ;
                end else begin
                    res_code_next = CODE_PROTOCOL;
                    res_cc_next   = '0;
                    state_next    = DONE;
                end
            end
            CC_REQ: state_next = CC_WAIT;
            CC_WAIT: begin
                res_cc_next = data_o_register;
                state_next  = DONE;
            end
            DONE: begin
                if (res_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        case (state_next)
            WR_CMD:  cmd_next = REG_WIDTH'(CMD_WRITE);
            START:   cmd_next = REG_WIDTH'(CMD_START);
            CC_REQ:  cmd_next = REG_WIDTH'(CMD_READ_ELAPSED_CLOCK);
            default: cmd_next = REG_WIDTH'(CMD_NOP);
        endcase
    end

    // State and register-port updates; reset returns everything to idle/NOP.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            timer_reg     <= '0;
            cmd_reg       <= REG_WIDTH'(CMD_NOP);
            addr_reg      <= '0;
            data_in_reg   <= '0;
            start_ptr_reg <= '0;
            end_ptr_reg   <= '0;
            res_code_reg  <= '0;
            res_cc_reg    <= '0;
        end else begin
            state_reg     <= state_next;
            timer_reg     <= timer_next;
            cmd_reg       <= cmd_next;
            addr_reg      <= addr_next;
            data_in_reg   <= data_in_next;
            start_ptr_reg <= start_ptr_next;
            end_ptr_reg   <= end_ptr_next;
            res_code_reg  <= res_code_next;
            res_cc_reg    <= res_cc_next;
        end
    end

`ifdef REGEX_SEQ_STATS_EN
    logic [CNT_WIDTH-1:0] stat_accepted_reg;
    logic [CNT_WIDTH-1:0] stat_rejected_reg;
    logic [CNT_WIDTH-1:0] stat_errors_reg;
    logic                 res_fire;

    assign res_fire      = (state_reg == DONE) && res_ready;
    assign stat_accepted = stat_accepted_reg;
    assign stat_rejected = stat_rejected_reg;
    assign stat_errors   = stat_errors_reg;

    // Saturating per-verdict counters, bumped when a result is consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_accepted_reg <= '0;
            stat_rejected_reg <= '0;
            stat_errors_reg   <= '0;
        end else if (res_fire) begin
            case (res_code_reg)
                CODE_ACCEPTED: begin
                    if (stat_accepted_reg != '1) stat_accepted_reg <= stat_accepted_reg + CNT_WIDTH'(1);
                end
                CODE_REJECTED: begin
                    if (stat_rejected_reg != '1) stat_rejected_reg <= stat_rejected_reg + CNT_WIDTH'(1);
                end
                default: begin
                    if (stat_errors_reg != '1) stat_errors_reg <= stat_errors_reg + CNT_WIDTH'(1);
                end
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_regex_job_sequencer.sv
// Testbench for regex_job_sequencer: a behavioural AXI_top core model reacts
// to the command register; expected results are queued when a job is issued
// and compared when the sequencer presents its result.

module tb_regex_job_sequencer;

    localparam int W          = 32;
    localparam int CMD_NOP    = 0;
    localparam int CMD_WRITE  = 1;
    localparam int CMD_START  = 2;
    localparam int CMD_READ   = 3;
    localparam int ST_IDLE    = 0;
    localparam int ST_RUNNING = 1;
    localparam int ST_ACCEPT  = 2;
    localparam int ST_REJECT  = 3;
    localparam int ST_BAD     = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         wr_valid = 1'b0;
    logic         wr_ready;
    logic [W-1:0] wr_addr = '0;
    logic [W-1:0] wr_data = '0;
    logic         job_valid = 1'b0;
    logic         job_ready;
    logic [W-1:0] job_start_cc = '0;
    logic [W-1:0] job_end_cc = '0;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic [1:0]   res_code;
    logic [W-1:0] res_cc;
    logic         busy;
    logic [W-1:0] address_register;
    logic [W-1:0] data_in_register;
    logic [W-1:0] start_cc_pointer_register;
    logic [W-1:0] end_cc_pointer_register;
    logic [W-1:0] cmd_register;
    logic [W-1:0] status_register = '0;
    logic [W-1:0] data_o_register = '0;
`ifdef REGEX_SEQ_STATS_EN
    logic [15:0]  stat_accepted;
    logic [15:0]  stat_rejected;
    logic [15:0]  stat_errors;
`endif

    regex_job_sequencer dut (
        .clk                       (clk),
        .rst                       (rst),
        .wr_valid                  (wr_valid),
        .wr_ready                  (wr_ready),
        .wr_addr                   (wr_addr),
        .wr_data                   (wr_data),
        .job_valid                 (job_valid),
        .job_ready                 (job_ready),
        .job_start_cc              (job_start_cc),
        .job_end_cc                (job_end_cc),
        .res_valid                 (res_valid),
        .res_ready                 (res_ready),
        .res_code                  (res_code),
        .res_cc                    (res_cc),
        .busy                      (busy),
        .address_register          (address_register),
        .data_in_register          (data_in_register),
        .start_cc_pointer_register (start_cc_pointer_register),
        .end_cc_pointer_register   (end_cc_pointer_register),
        .cmd_register              (cmd_register),
        .status_register           (status_register),
        .data_o_register           (data_o_register)
`ifdef REGEX_SEQ_STATS_EN
        ,
        .stat_accepted             (stat_accepted),
        .stat_rejected             (stat_rejected),
        .stat_errors               (stat_errors)
`endif
    );

    always #5 clk = ~clk;

    // core model configuration (written only by the stimulus process)
    int           core_mode    = 0;    // 0: never reports RUNNING, 1: normal
    int           run_delay    = 2;    // START cycles before RUNNING appears
    int           run_len      = 2;    // RUNNING cycles before final status
    logic [W-1:0] final_status = W'(ST_ACCEPT);
    logic [W-1:0] core_cc      = '0;

    // core model / monitor state (written only by the model process)
    int           start_seen   = 0;
    int           run_left     = 0;
    int           start_cycles = 0;
    int           write_cycles = 0;
    int           nonnop_cycles = 0;
    int           violations   = 0;
    logic [W-1:0] prev_cmd     = '0;
    logic [W-1:0] last_wr_addr = '0;
    logic [W-1:0] last_wr_data = '0;

    // scoreboard and counters
    logic [W+1:0] exp_q[$];
    int           n_cmp = 0;
    int           n_err = 0;
    int           tally_acc = 0;
    int           tally_rej = 0;
    int           tally_err = 0;

    // Behavioural AXI_top core plus command-stream monitor, on the falling edge.
    always @(negedge clk) begin
        if (cmd_register != W'(CMD_NOP)) nonnop_cycles++;
        if (cmd_register == W'(CMD_START)) start_cycles++;
        if (cmd_register == W'(CMD_WRITE)) begin
            write_cycles++;
            last_wr_addr = address_register;
            last_wr_data = data_in_register;
        end
        if (prev_cmd != W'(CMD_NOP) && cmd_register != W'(CMD_NOP) &&
            !(prev_cmd == W'(CMD_START) && cmd_register == W'(CMD_START)))
            violations++;
        prev_cmd = cmd_register;

        if (!busy) begin
            status_register = W'(ST_IDLE);
            data_o_register = '0;
            start_seen      = 0;
        end else if (cmd_register == W'(CMD_START)) begin
            if (core_mode == 1) begin
                start_seen++;
                if (start_seen >= run_delay) begin
                    status_register = W'(ST_RUNNING);
                    run_left        = run_len;
                end
            end
        end else if (status_register == W'(ST_RUNNING)) begin
            if (run_left == 0) status_register = final_status;
            else run_left--;
        end
        if (cmd_register == W'(CMD_READ)) data_o_register = core_cc;
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    // Advance to just after the falling edge: DUT outputs and the model are settled.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic set_core(input int mode, input int dly, input int len,
                            input logic [W-1:0] fin, input logic [W-1:0] cc);
        core_mode    = mode;
        run_delay    = dly;
        run_len      = len;
        final_status = fin;
        core_cc      = cc;
    endtask

    task automatic do_job(input string tag, input logic [W-1:0] sp, input logic [W-1:0] ep,
                          input logic [1:0] ec, input logic [W-1:0] ecc);
        int n;
        logic [W+1:0] e;
        exp_q.push_back({ec, ecc});
        job_start_cc = sp;
        job_end_cc   = ep;
        job_valid    = 1'b1;
        n = 0;
        while (!job_ready && n < 100) begin step(); n++; end
        check_val({tag, "_job_ready"}, 64'(job_ready), 64'd1);
        step();
        job_valid = 1'b0;
        n = 0;
        while (!res_valid && n < 300) begin step(); n++; end
        check_val({tag, "_res_valid"}, 64'(res_valid), 64'd1);
        e = exp_q.pop_front();
        check_val({tag, "_code"}, 64'(res_code), 64'(e[W+1:W]));
        check_val({tag, "_cc"}, 64'(res_cc), 64'(e[W-1:0]));
        step();
        step();
        check_val({tag, "_code_held"}, 64'(res_code), 64'(e[W+1:W]));
        check_val({tag, "_valid_held"}, 64'(res_valid), 64'd1);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        check_val({tag, "_idle_after"}, 64'({res_valid, busy}), 64'd0);
        if (e[W+1:W] == 2'b01) tally_acc++;
        else if (e[W+1:W] == 2'b00) tally_rej++;
        else tally_err++;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, w0, n0, n;

        // reset state
        rst = 1'b1;
        repeat (3) step();
        check_val("rst_cmd", 64'(cmd_register), 64'(CMD_NOP));
        check_val("rst_busy_valid", 64'({busy, res_valid}), 64'd0);
        check_val("rst_code", 64'(res_code), 64'd0);
        check_val("rst_cc", 64'(res_cc), 64'd0);
        check_val("rst_regs", 64'(address_register | data_in_register |
                  start_cc_pointer_register | end_cc_pointer_register), 64'd0);
        rst = 1'b0;
        step();
        check_val("idle_ready", 64'({wr_ready, job_ready}), 64'b11);

        // single write beat
        w0 = write_cycles;
        wr_addr  = 32'h5;
        wr_data  = 32'hDEADBEEF;
        wr_valid = 1'b1;
        step();
        wr_valid = 1'b0;
        check_val("wr_addr_reg", 64'(address_register), 64'h5);
        check_val("wr_data_reg", 64'(data_in_register), 64'hDEADBEEF);
        check_val("wr_setup_cmd", 64'(cmd_register), 64'(CMD_NOP));
        check_val("wr_setup_ready", 64'(wr_ready), 64'd0);
        step();
        check_val("wr_cmd_write", 64'(cmd_register), 64'(CMD_WRITE));
        check_val("wr_cmd_ready", 64'(wr_ready), 64'd0);
        step();
        check_val("wr_after_cmd", 64'(cmd_register), 64'(CMD_NOP));
        check_val("wr_ready_back", 64'(wr_ready), 64'd1);
        check_val("wr_count", 64'(write_cycles - w0), 64'd1);
        check_val("wr_core_data", 64'(last_wr_data), 64'hDEADBEEF);

        // accepted job, RUNNING two cycles after START
        set_core(1, 2, 3, W'(ST_ACCEPT), 32'd123);
        s0 = start_cycles;
        do_job("acc", 32'h40, 32'h4F, 2'b01, 32'd123);
        check_val("acc_start_cycles", 64'(start_cycles - s0), 64'd2);
        check_val("acc_ptrs", {start_cc_pointer_register, end_cc_pointer_register}, {32'h40, 32'h4F});

        // start timeout
        set_core(0, 2, 3, W'(ST_ACCEPT), 32'd999);
        s0 = start_cycles;
        do_job("tmo", 32'h0, 32'h8, 2'b10, 32'd0);
        check_val("tmo_start_cycles", 64'(start_cycles - s0), 64'd16);

        // inverted pointers: core untouched
        n0 = nonnop_cycles;
        do_job("bad_ptr", 32'h50, 32'h4F, 2'b11, 32'd0);
        check_val("bad_ptr_nonnop", 64'(nonnop_cycles - n0), 64'd0);

        // rejected verdict and unexpected status
        set_core(1, 1, 1, W'(ST_REJECT), 32'd55);
        do_job("rej", 32'h10, 32'h10, 2'b00, 32'd55);
        set_core(1, 1, 0, W'(ST_BAD), 32'd66);
        do_job("proto", 32'h20, 32'h30, 2'b11, 32'd0);

        // write and job together: write first
        set_core(1, 1, 2, W'(ST_ACCEPT), 32'd77);
        w0 = write_cycles;
        wr_addr  = 32'h7;
        wr_data  = 32'h1234;
        job_start_cc = 32'h10;
        job_end_cc   = 32'h20;
        wr_valid  = 1'b1;
        job_valid = 1'b1;
        #1;
        check_val("both_job_ready", 64'(job_ready), 64'd0);
        check_val("both_wr_ready", 64'(wr_ready), 64'd1);
        step();
        wr_valid = 1'b0;
        check_val("both_wr_taken", 64'(address_register), 64'h7);
        do_job("both_job", 32'h10, 32'h20, 2'b01, 32'd77);
        check_val("both_wr_count", 64'(write_cycles - w0), 64'd1);
        check_val("both_wr_core_addr", 64'(last_wr_addr), 64'h7);

        // reset during RUN
        set_core(1, 1, 1000, W'(ST_ACCEPT), 32'd88);
        job_start_cc = 32'h1;
        job_end_cc   = 32'h2;
        job_valid    = 1'b1;
        step();
        job_valid = 1'b0;
        n = 0;
        while (status_register != W'(ST_RUNNING) && n < 50) begin step(); n++; end
        step();
        step();
        check_val("run_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        step();
        check_val("rst_run_cmd", 64'(cmd_register), 64'(CMD_NOP));
        check_val("rst_run_busy_valid", 64'({busy, res_valid}), 64'd0);
        rst = 1'b0;
        tally_acc = 0;
        tally_rej = 0;
        tally_err = 0;
        step();

        // three accepted jobs
        for (int i = 0; i < 3; i++) begin
            set_core(1, 1 + i, i, W'(ST_ACCEPT), W'(200 + i));
            do_job($sformatf("acc3_%0d", i), W'(i), W'(i + 4), 2'b01, W'(200 + i));
        end
`ifdef REGEX_SEQ_STATS_EN
        check_val("stat_accepted", 64'(stat_accepted), 64'(tally_acc));
        check_val("stat_rejected", 64'(stat_rejected), 64'(tally_rej));
        check_val("stat_errors", 64'(stat_errors), 64'(tally_err));
`endif

        check_val("cmd_spacing_violations", 64'(violations), 64'd0);
        check_val("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
